sp_bram_cmd_writer: RTL
=======================

Name: sp_bram_cmd_writer

Overview:
- Host-side writer for the special-purpose (SP) BRAM mailbox; the initiator for the accelerator FSM that polls the start word at byte address 0.
- Accepts one command (NUM_VAR argument words) per valid/ready handshake, writes the arguments into the SP BRAM, then writes the start word.
- Polls the done word until the accelerator posts a nonzero status, clears both mailbox words, and returns the status.

Parameters:
- NUM_VAR, 8, argument words per command (1..64).
- DATA_WIDTH, 32, BRAM word width; fixed at 32.
- START_ADDR, 0, byte address of the start word.
- ARG_BASE, 4, byte address of argument 0; argument i is at ARG_BASE+4*i.
- DONE_ADDR, 252, byte address of the done/status word.
- POLL_LIMIT, 0, maximum done polls before timeout; 0 means no limit.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_args  in  NUM_VAR*32  argument i is bits [32*i+31:32*i]; captured on handshake.
- start_val  in  32  value written to START_ADDR; captured on handshake; 0 is treated as 1.
- busy  out  1  high in every state except IDLE.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_status  out  32  done word read back, or 32'hFFFF_FFFF on timeout; held until the next rsp_valid.
- addr_sp_bram  out  32  byte address.
- enable_sp_bram  out  1  BRAM enable.
- w_enable_sp_bram  out  4  byte write enables; 4'hF on a write, 0 on a read.
- data_in_sp_bram  out  32  write data.
- data_out_sp_bram  in  32  read data; 1-cycle latency (address in cycle N, data valid in cycle N+1).

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; cmd_ready=1; busy=0; rsp_valid=0; rsp_status=0.
  - addr=0; enable=0; w_enable=0; data_in=0.
  - Arguments, argument counter and poll counter cleared.
- Reset mid-command: BRAM bus returns to idle immediately. Mailbox contents are left as written; no cleanup is performed.
- IDLE: bus idle (enable=0).
  - On cmd_valid & cmd_ready, capture cmd_args and start_val; go to WR_ARG with i=0.
- WR_ARG: ports carry addr=ARG_BASE+4*i, enable=1, w_enable=F, data_in=arg[i]. One word per cycle.
  - After i=NUM_VAR-1, go to WR_START.
- WR_START: one cycle; write start_val (or 1 if start_val=0) to START_ADDR; go to POLL_RD.
  - Ordering guarantee: the start write is never issued before the last argument write.
- POLL_RD: one cycle; read DONE_ADDR (enable=1, w_enable=0); increment poll counter; go to POLL_CHK.
- POLL_CHK: bus idle; sample data_out_sp_bram.
  - Nonzero: latch it as status; go to CLR_DONE.
  - Zero and POLL_LIMIT!=0 and poll count==POLL_LIMIT: status=32'hFFFF_FFFF; go to CLR_DONE.
  - Otherwise: back to POLL_RD. A poll therefore repeats every 2 cycles.
- CLR_DONE: write 0 to DONE_ADDR. Then CLR_START: write 0 to START_ADDR.
- RESP: rsp_valid=1 for one cycle; rsp_status updated in the same cycle; go to IDLE.
  - cmd_ready returns on the following cycle. Back-to-back commands are therefore separated by at least one IDLE cycle.
- Latency, handshake to rsp_valid with done seen on the k-th poll: NUM_VAR + 1 + 2k + 3 cycles.
- cmd_valid while busy is ignored; there is no queueing.
- Counters are sized $clog2(NUM_VAR+1) and 32 bits. The poll counter saturates and never wraps.

Decomposition:
- Shared package sp_bram_pkg holds:
  - state encoding as a 6-bit enum: IDLE, WR_ARG, WR_START, POLL_RD, POLL_CHK, CLR_DONE, CLR_START, RESP;
  - BRAM constants: WORD_BYTES=4, WE_ALL=4'hF;
  - TIMEOUT_STATUS=32'hFFFF_FFFF.
- No sub-module. The BRAM port driver is a single registered mux inside the FSM. The bench instantiates a 1-cycle-latency SP BRAM model plus an accelerator stub that writes the done word after a programmable delay.

Test Plan:
- Reset, then NUM_VAR=8, args 0x10..0x17, start_val=1, stub posts done=0x5 after 3 polls -> writes at 4..32 with 0x10..0x17 in order, then 0x1 at addr 0, polls at 252, clears 252 then 0, rsp_valid with rsp_status=0x5 exactly 8+1+6+3=18 cycles after handshake.
- start_val=0 -> word 1 written to START_ADDR; rest identical.
- POLL_LIMIT=4, stub never answers -> exactly 4 reads of 252, both clears performed, rsp_status=0xFFFF_FFFF.
- cmd_valid held high across a whole command with new args -> second command accepted only after a cycle with cmd_ready=1 post-RESP; first command's args unaffected.
- rst asserted asynchronously during WR_ARG at i=3 -> enable/w_enable drop to 0 the same cycle without a clock edge; busy=0, cmd_ready=1, no start write ever issued.
- Stub answers on the first poll with 0x8000_0001 -> rsp_status=0x8000_0001, single poll observed, latency 8+1+2+3=14.

Source files
------------

// File: rtl/sp_bram_pkg.sv
// Shared definitions for the SP BRAM mailbox command writer: FSM encoding,
// BRAM byte-enable constants and the status reported when polling gives up.
package sp_bram_pkg;

  typedef enum logic [5:0] {
    IDLE,
    WR_ARG,
    WR_START,
    POLL_RD,
    POLL_CHK,
    CLR_DONE,
    CLR_START,
    RESP
  } state_e;

  localparam int unsigned WORD_BYTES     = 4;
  localparam logic [3:0]  WE_ALL         = 4'hF;
  localparam logic [31:0] TIMEOUT_STATUS = 32'hFFFF_FFFF;

endpackage

// File: rtl/sp_bram_cmd_writer.sv
// Writes a command's arguments and start word into the SP BRAM mailbox, polls the done word
// and returns its status. One command in flight; cmd_ready only in IDLE, latency NUM_VAR+4+2k.
module sp_bram_cmd_writer
  import sp_bram_pkg::*;
#(
  parameter int unsigned NUM_VAR    = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned ARG_BASE   = 4,
  parameter int unsigned DONE_ADDR  = 252,
  parameter int unsigned POLL_LIMIT = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [NUM_VAR*DATA_WIDTH-1:0]   cmd_args,
  input  logic [DATA_WIDTH-1:0]           start_val,
  output logic                            busy,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_status,
  output logic [31:0]                     addr_sp_bram,
  output logic                            enable_sp_bram,
  output logic [3:0]                      w_enable_sp_bram,
  output logic [DATA_WIDTH-1:0]           data_in_sp_bram,
  input  logic [DATA_WIDTH-1:0]           data_out_sp_bram
);

  localparam int CNT_W = $clog2(NUM_VAR + 1);
  localparam int IDX_W = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;

  typedef logic [NUM_VAR-1:0][DATA_WIDTH-1:0] args_t;

  state_e                state_q, state_d;
  args_t                 args_q, args_d;
  logic [DATA_WIDTH-1:0] start_q, start_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           poll_q, poll_d;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_status_q, rsp_status_d;
  logic [31:0]           addr_q, addr_d;
  logic                  en_q, en_d;
  logic [3:0]            we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]      idx_d;

  always_comb begin
    state_d  = state_q;
    args_d   = args_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    poll_d   = poll_q;
    status_d = status_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          args_d  = cmd_args;
          start_d = (start_val == '0) ? DATA_WIDTH'(1) : start_val;
          cnt_d   = '0;
          poll_d  = '0;
          state_d = WR_ARG;
        end
      end
      WR_ARG: begin
        if (cnt_q == CNT_W'(NUM_VAR - 1)) begin
          state_d = WR_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_START: state_d = POLL_RD;
      POLL_RD: begin
        // Saturate rather than wrap so an unlimited poll never aliases a limit.
        if (poll_q != '1) poll_d = poll_q + 32'd1;
        state_d = POLL_CHK;
      end
      POLL_CHK: begin
        if (data_out_sp_bram != '0) begin
          status_d = data_out_sp_bram;
          state_d  = CLR_DONE;
        end else if (POLL_LIMIT != 0 && poll_q == 32'(POLL_LIMIT)) begin
          status_d = TIMEOUT_STATUS;
          state_d  = CLR_DONE;
        end else begin
          state_d = POLL_RD;
        end
      end
      CLR_DONE:  state_d = CLR_START;
      CLR_START: state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Bus and response outputs are decoded from the next state and registered,
    // so each state's BRAM access is on the pins for exactly that state's cycle.
    rsp_valid_d  = (state_d == RESP);
    rsp_status_d = (state_d == RESP) ? status_d : rsp_status_q;
    addr_d       = '0;
    en_d         = 1'b0;
    we_d         = '0;
    wdata_d      = '0;
    idx_d        = cnt_d[IDX_W-1:0];

    case (state_d)
      WR_ARG: begin
        addr_d  = 32'(ARG_BASE) + 32'(cnt_d) * 32'(WORD_BYTES);
        en_d    = 1'b1;
        we_d    = WE_ALL;
        wdata_d = args_d[idx_d];
      end
      WR_START: begin
        addr_d  = 32'(START_ADDR);
        en_d    = 1'b1;
        we_d    = WE_ALL;
        wdata_d = start_d;
      end
      POLL_RD: begin
        addr_d = 32'(DONE_ADDR);
        en_d   = 1'b1;
      end
      CLR_DONE: begin
        addr_d = 32'(DONE_ADDR);
        en_d   = 1'b1;
        we_d   = WE_ALL;
      end
      CLR_START: begin
        addr_d = 32'(START_ADDR);
        en_d   = 1'b1;
        we_d   = WE_ALL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      args_q       <= '0;
      start_q      <= '0;
      cnt_q        <= '0;
      poll_q       <= '0;
      status_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      addr_q       <= '0;
      en_q         <= 1'b0;
      we_q         <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      args_q       <= args_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      poll_q       <= poll_d;
      status_q     <= status_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      addr_q       <= addr_d;
      en_q         <= en_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign rsp_valid        = rsp_valid_q;
  assign rsp_status       = rsp_status_q;
  assign addr_sp_bram     = addr_q;
  assign enable_sp_bram   = en_q;
  assign w_enable_sp_bram = we_q;
  assign data_in_sp_bram  = wdata_q;

endmodule
